// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the RV32 hazard controller: forwarding select
// encoding and the default register-address width.
package pipeline_pkg;

  localparam int REG_AW_DEF = 5;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_W   = 2'b01,
    FWD_M   = 2'b10
  } fwd_sel_t;

  // M wins over W because it holds the younger result.
  function automatic fwd_sel_t fwdSel(input logic hitM, input logic hitW);
    fwd_sel_t sel;
    if (hitM) begin
      sel = FWD_M;
    end else if (hitW) begin
      sel = FWD_W;
    end else begin
      sel = FWD_REG;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_md_timer.sv
// Blocking multi-cycle execute-unit timer: holds an MDU op in E for MD_LAT
// extra cycles, then lets it go once md_done is seen.
module hazard_md_timer
  import pipeline_pkg::*;
#(
  parameter int MD_LAT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic MdOpE,
  input  logic StallE,
  output logic mdStall,
  output logic MdBusy
);

  localparam logic [7:0] LOAD_VAL = (MD_LAT > 1) ? 8'(MD_LAT - 1) : 8'd0;
  localparam logic       LAT_EN   = (MD_LAT != 0);
  localparam logic       LAT_ONE  = (MD_LAT == 1);

  logic [7:0] mdCnt_r;
  logic [7:0] mdCntNext_s;
  logic       mdDone_r;
  logic       mdDoneNext_s;
  logic       setDone_s;

  assign mdStall = LAT_EN & MdOpE & ~mdDone_r;
  assign MdBusy  = (mdCnt_r != 8'd0);

  // Next-state for the countdown and the done flag; done survives only while E is held.
  always_comb begin
    mdCntNext_s  = mdCnt_r;
    mdDoneNext_s = mdDone_r;
    setDone_s    = (mdCnt_r == 8'd1) | ((mdCnt_r == 8'd0) & mdStall & LAT_ONE);
    if (mdCnt_r != 8'd0) begin
      mdCntNext_s = mdCnt_r - 8'd1;
    end else if (mdStall & ~LAT_ONE) begin
      mdCntNext_s = LOAD_VAL;
    end else begin
      mdCntNext_s = mdCnt_r;
    end
    if (setDone_s) begin
      mdDoneNext_s = 1'b1;
    end else if (!StallE) begin
      mdDoneNext_s = 1'b0;
    end else begin
      mdDoneNext_s = mdDone_r;
    end
  end

  // Timer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdCnt_r  <= 8'd0;
      mdDone_r <= 1'b0;
    end else begin
      mdCnt_r  <= mdCntNext_s;
      mdDone_r <= mdDoneNext_s;
    end
  end

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller for the 5-stage RV32 pipeline: forwarding, load-use and
// MDU/memory stalls, branch flush, and a saturating stall-cycle counter.
module hazard_ctrl_mc
  import pipeline_pkg::*;
#(
  parameter int REG_AW = REG_AW_DEF,
  parameter int MD_LAT = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic              UseRs1D,
  input  logic              UseRs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic              RegWriteE,
  input  logic              ResultSrcE0,
  input  logic              MdOpE,
  input  logic              PCSrcE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              MemReadyM,
  input  logic              ClrStats,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              StallM,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic              FlushW,
  output logic              MdBusy,
  output logic [CNT_W-1:0]  StallCycles
);

  localparam logic [REG_AW-1:0] REG_ZERO = {REG_AW{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

  logic lwStall_s;
  logic memStall_s;
  logic mdStall_s;
  logic frozen_s;

  // x0 is hard-wired zero and must never be forwarded.
  assign ForwardAE = fwdSel((Rs1E != REG_ZERO) & RegWriteM & (Rs1E == RdM),
                            (Rs1E != REG_ZERO) & RegWriteW & (Rs1E == RdW));
  assign ForwardBE = fwdSel((Rs2E != REG_ZERO) & RegWriteM & (Rs2E == RdM),
                            (Rs2E != REG_ZERO) & RegWriteW & (Rs2E == RdW));

  assign lwStall_s  = ResultSrcE0 & RegWriteE & (RdE != REG_ZERO) &
                      ((UseRs1D & (Rs1D == RdE)) | (UseRs2D & (Rs2D == RdE)));
  assign memStall_s = ~MemReadyM;
  assign frozen_s   = memStall_s | mdStall_s;

  assign StallF = frozen_s | lwStall_s;
  assign StallD = frozen_s | lwStall_s;
  assign StallE = frozen_s;
  assign StallM = memStall_s;
  assign FlushW = memStall_s;
  assign FlushM = mdStall_s & ~memStall_s;
  // A held branch is deferred until the pipeline can move again.
  assign FlushE = ~frozen_s & (lwStall_s | PCSrcE);
  assign FlushD = ~frozen_s & PCSrcE;

  hazard_md_timer #(
    .MD_LAT (MD_LAT)
  ) u_md_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .MdOpE   (MdOpE),
    .StallE  (StallE),
    .mdStall (mdStall_s),
    .MdBusy  (MdBusy)
  );

  // Stall statistics: clear wins, otherwise count StallF cycles up to all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      StallCycles <= {CNT_W{1'b0}};
    end else if (ClrStats) begin
      StallCycles <= {CNT_W{1'b0}};
    end else if (StallF && (StallCycles != CNT_MAX)) begin
      StallCycles <= StallCycles + CNT_ONE;
    end else begin
      StallCycles <= StallCycles;
    end
  end

endmodule
